// File: rtl/fp_pkg.sv
// Shared FP32 constants, state encoding and operand class type
// for the sequential single-precision multiplier.
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int MANT_W = FRAC_W + 1;
    localparam int PROD_W = 2 * MANT_W;
    localparam int BIAS   = 127;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_MUL  = 2'd1;
    localparam state_t ST_NORM = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    typedef struct packed {
        logic nan;
        logic inf;
        logic zero;
    } fp_cls_t;

endpackage

// File: rtl/fp_unpack.sv
// Splits an FP32 word into sign, exponent and {hidden,frac} mantissa and
// classifies it. Ports: op in; sign, exp, mant, cls out. Denormals -> zero.
module fp_unpack
    import fp_pkg::*;
(
    input  logic [31:0]       op,
    output logic              sign,
    output logic [EXP_W-1:0]  exp,
    output logic [MANT_W-1:0] mant,
    output fp_cls_t           cls
);

    logic exp_zero;
    logic exp_max;
    logic frac_nz;

    assign sign     = op[31];
    assign exp      = op[30:23];
    assign exp_zero = (exp == '0);
    assign exp_max  = &exp;
    assign frac_nz  = |op[22:0];

    // Flushed denormals carry a zero mantissa so the product is zero too.
    assign mant = exp_zero ? '0 : {1'b1, op[22:0]};

    assign cls.zero = exp_zero;
    assign cls.inf  = exp_max & ~frac_nz;
    assign cls.nan  = exp_max & frac_nz;

endmodule

// File: rtl/fp_mul_seq.sv
// Sequential FP32 multiplier: shift-add mantissa, fixed 26-cycle latency.
// Ports: clk, rst_n, start, in1, in2 -> ready, done, final_o, ovf, unf.
// Build option FP_MUL_RNE_EN selects round-nearest-even (else truncate).
module fp_mul_seq
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    output logic        ready,
    output logic        done,
    // "final" is a reserved word, so the product port is final_o.
    output logic [31:0] final_o,
    output logic        ovf,
    output logic        unf
);

    state_t            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [31:0]       op_a_q, op_a_d;
    logic [31:0]       op_b_q, op_b_d;
    logic [PROD_W-1:0] prod_q, prod_d;
    logic [MANT_W-1:0] nm_q, nm_d;
    logic signed [9:0] ne_q, ne_d;
    logic              g_q, g_d;
    logic              r_q, r_d;
    logic              s_q, s_d;
    logic [31:0]       final_q, final_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic              sa, sb;
    logic [EXP_W-1:0]  ea, eb;
    logic [MANT_W-1:0] ma, mb;
    fp_cls_t           ca, cb;

    logic              sign;
    logic signed [9:0] exp_sum;
    logic              is_nan, is_inf, is_zero;
    logic              rnd_inc;
    logic [MANT_W:0]   sum25;
    logic [MANT_W-1:0] mr;
    logic signed [9:0] er;
    logic              unused_mr;

    fp_unpack u_unpack_a (
        .op   (op_a_q),
        .sign (sa),
        .exp  (ea),
        .mant (ma),
        .cls  (ca)
    );

    fp_unpack u_unpack_b (
        .op   (op_b_q),
        .sign (sb),
        .exp  (eb),
        .mant (mb),
        .cls  (cb)
    );

    assign sign    = sa ^ sb;
    assign exp_sum = 10'(ea) + 10'(eb) - 10'(BIAS);

    assign is_nan  = ca.nan | cb.nan
                   | (ca.zero & cb.inf)
                   | (ca.inf & cb.zero);
    assign is_inf  = ca.inf | cb.inf;
    assign is_zero = ca.zero | cb.zero;

`ifdef FP_MUL_RNE_EN
    // Ties go to the even mantissa: bump only when the lsb is odd.
    assign rnd_inc = g_q & (r_q | s_q | nm_q[0]);
`else
    logic unused_rnd;
    assign rnd_inc    = 1'b0;
    assign unused_rnd = ^{g_q, r_q, s_q};
`endif

    assign sum25 = {1'b0, nm_q} + {{MANT_W{1'b0}}, rnd_inc};

    // Rounding carry-out means 1.111.. became 10.000..; renormalize.
    always_comb begin
        mr = sum25[MANT_W-1:0];
        er = ne_q;
        if (sum25[MANT_W]) begin
            mr = sum25[MANT_W:1];
            er = ne_q + 10'sd1;
        end
    end

    assign unused_mr = mr[MANT_W-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        prod_d  = prod_q;
        nm_d    = nm_q;
        ne_d    = ne_q;
        g_d     = g_q;
        r_d     = r_q;
        s_d     = s_q;
        final_d = final_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_a_d  = in1;
                    op_b_d  = in2;
                    prod_d  = '0;
                    cnt_d   = 5'd23;
                    state_d = ST_MUL;
                end
            end

            ST_MUL: begin
                // MSB-first shift-add over the multiplier bits.
                prod_d = {prod_q[PROD_W-2:0], 1'b0}
                       + (mb[cnt_q] ? {{MANT_W{1'b0}}, ma}
                                    : {PROD_W{1'b0}});
                if (cnt_q == 5'd0) begin
                    cnt_d   = 5'd1;
                    state_d = ST_NORM;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end

            ST_NORM: begin
                if (cnt_q != 5'd0) begin
                    // First NORM cycle: align and capture g/r/sticky.
                    cnt_d = 5'd0;
                    if (prod_q[47]) begin
                        nm_d = prod_q[47:24];
                        g_d  = prod_q[23];
                        r_d  = prod_q[22];
                        s_d  = |prod_q[21:0];
                        ne_d = exp_sum + 10'sd1;
                    end else begin
                        nm_d = prod_q[46:23];
                        g_d  = prod_q[22];
                        r_d  = prod_q[21];
                        s_d  = |prod_q[20:0];
                        ne_d = exp_sum;
                    end
                end else begin
                    // Second NORM cycle: round, classify, pack.
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    state_d = ST_DONE;
                    if (is_nan) begin
                        final_d = QNAN;
                    end else if (is_inf) begin
                        final_d = {sign, 8'hFF, 23'h0};
                    end else if (is_zero) begin
                        final_d = {sign, 31'h0};
                    end else if (er >= 10'sd255) begin
                        final_d = {sign, 8'hFF, 23'h0};
                        ovf_d   = 1'b1;
                    end else if (er <= 10'sd0) begin
                        final_d = {sign, 31'h0};
                        unf_d   = 1'b1;
                    end else begin
                        final_d = {sign, er[7:0], mr[22:0]};
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            prod_q  <= '0;
            nm_q    <= '0;
            ne_q    <= '0;
            g_q     <= 1'b0;
            r_q     <= 1'b0;
            s_q     <= 1'b0;
            final_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            prod_q  <= prod_d;
            nm_q    <= nm_d;
            ne_q    <= ne_d;
            g_q     <= g_d;
            r_q     <= r_d;
            s_q     <= s_d;
            final_q <= final_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign ready   = (state_q == ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign final_o = final_q;
    assign ovf     = ovf_q;
    assign unf     = unf_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed bench for fp_mul_seq: hand-computed products, flags,
// latency, busy-start rejection and mid-operation reset.
module tb_fp_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        ready;
    logic        done;
    logic [31:0] final_o;
    logic        ovf;
    logic        unf;

    int total = 0;
    int bad   = 0;

    localparam int NV = 16;
    logic [31:0] va [NV];
    logic [31:0] vb [NV];
    logic [31:0] vr [NV];
    logic [1:0]  vf [NV];

    fp_mul_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .in1     (in1),
        .in2     (in2),
        .ready   (ready),
        .done    (done),
        .final_o (final_o),
        .ovf     (ovf),
        .unf     (unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic run_op(input  logic [31:0] a,
                          input  logic [31:0] b,
                          input  bit          poke,
                          output logic [31:0] r,
                          output logic        o,
                          output logic        u,
                          output int          lat);
        @(negedge clk);
        in1   = a;
        in2   = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        in1   = 32'hDEAD_BEEF;
        in2   = 32'h1234_5678;
        lat   = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k == 3)
                chk("ready_busy", {31'h0, ready}, 32'h0);
            if (poke && k == 5) begin
                start = 1'b1;
                in1   = 32'h7F80_0000;
                in2   = 32'h0000_0000;
            end
            if (poke && k == 8)
                start = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
        end
        r = final_o;
        o = ovf;
        u = unf;
        @(posedge clk);
        #1;
        chk("ready_idle", {31'h0, ready}, 32'h1);
    endtask

    task automatic watch_done(input int cycles, output int nd);
        nd = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
            if (done)
                nd++;
        end
    endtask

    initial begin
        logic [31:0] r;
        logic        o;
        logic        u;
        int          lat;
        int          nd;

        va[0]  = 32'h3FC0_0000; vb[0]  = 32'h4000_0000;
        vr[0]  = 32'h4040_0000; vf[0]  = 2'b00;
        va[1]  = 32'hC040_0000; vb[1]  = 32'h3F00_0000;
        vr[1]  = 32'hBFC0_0000; vf[1]  = 2'b00;
        va[2]  = 32'h7F00_0000; vb[2]  = 32'h7F00_0000;
        vr[2]  = 32'h7F80_0000; vf[2]  = 2'b10;
        va[3]  = 32'h0080_0000; vb[3]  = 32'h0080_0000;
        vr[3]  = 32'h0000_0000; vf[3]  = 2'b01;
        va[4]  = 32'h0000_0000; vb[4]  = 32'h7F80_0000;
        vr[4]  = 32'h7FC0_0000; vf[4]  = 2'b00;
        va[5]  = 32'h7F80_0000; vb[5]  = 32'hC000_0000;
        vr[5]  = 32'hFF80_0000; vf[5]  = 2'b00;
        va[6]  = 32'h3FC0_0001; vb[6]  = 32'h3FC0_0001;
`ifdef FP_MUL_RNE_EN
        vr[6]  = 32'h4010_0002;
`else
        vr[6]  = 32'h4010_0001;
`endif
        vf[6]  = 2'b00;
        va[7]  = 32'h8000_0000; vb[7]  = 32'h3F80_0000;
        vr[7]  = 32'h8000_0000; vf[7]  = 2'b00;
        va[8]  = 32'h0000_0001; vb[8]  = 32'h4000_0000;
        vr[8]  = 32'h0000_0000; vf[8]  = 2'b00;
        va[9]  = 32'h7FC0_0000; vb[9]  = 32'h3F80_0000;
        vr[9]  = 32'h7FC0_0000; vf[9]  = 2'b00;
        va[10] = 32'hFF80_0000; vb[10] = 32'hFF80_0000;
        vr[10] = 32'h7F80_0000; vf[10] = 2'b00;
        va[11] = 32'h3F80_0000; vb[11] = 32'h3F80_0000;
        vr[11] = 32'h3F80_0000; vf[11] = 2'b00;
        va[12] = 32'h2000_0000; vb[12] = 32'h1F80_0000;
        vr[12] = 32'h0000_0000; vf[12] = 2'b01;
        va[13] = 32'h7F00_0000; vb[13] = 32'h4000_0000;
        vr[13] = 32'h7F80_0000; vf[13] = 2'b10;
        va[14] = 32'h7F00_0000; vb[14] = 32'h3F80_0000;
        vr[14] = 32'h7F00_0000; vf[14] = 2'b00;
        va[15] = 32'h3F7F_FFFF; vb[15] = 32'h3F80_0001;
        vr[15] = 32'h3F80_0000; vf[15] = 2'b00;

        rst_n = 1'b0;
        start = 1'b0;
        in1   = '0;
        in2   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'h0, ready}, 32'h1);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_final", final_o, 32'h0);
        chk("rst_flags", {30'h0, ovf, unf}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            run_op(va[i], vb[i], 1'b0, r, o, u, lat);
            chk($sformatf("res%0d", i), r, vr[i]);
            chk($sformatf("flg%0d", i), {30'h0, o, u},
                {30'h0, vf[i]});
            chk($sformatf("lat%0d", i), lat, 32'd26);
        end

        run_op(32'h3FC0_0000, 32'h4000_0000, 1'b1, r, o, u, lat);
        chk("busy_res", r, 32'h4040_0000);
        chk("busy_lat", lat, 32'd26);
        watch_done(40, nd);
        chk("busy_no_done", nd, 32'd0);
        chk("busy_hold", final_o, 32'h4040_0000);

        @(negedge clk);
        in1   = 32'h3F80_0000;
        in2   = 32'h4000_0000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_ready", {31'h0, ready}, 32'h1);
        chk("mrst_done", {31'h0, done}, 32'h0);
        chk("mrst_final", final_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        watch_done(40, nd);
        chk("mrst_no_done", nd, 32'd0);

        run_op(32'h3F80_0000, 32'h4000_0000, 1'b0, r, o, u, lat);
        chk("post_res", r, 32'h4000_0000);
        chk("post_lat", lat, 32'd26);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_mul_seq.md
FP_MUL_SEQ -- requirements
Module: fp_mul_seq

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock; rst_n  input  1  async active-low reset.
REQ-002 SHALL have: start  input  1  request; sampled only when ready=1.
REQ-003 SHALL have: in1  input  32  IEEE-754 single operand A; in2  input  32  operand B.
REQ-004 SHALL have: ready  output  1  high only in IDLE.
REQ-005 SHALL have: done  output  1  one-cycle result-valid pulse.
REQ-006 SHALL have: final  output  32  product, held until the next done.
REQ-007 SHALL have: ovf  output  1  overflow flag; unf  output  1  underflow flag; both valid with done.

Function
REQ-008 SHALL implement FSM IDLE -> MUL -> NORM -> DONE -> IDLE.
REQ-009 SHALL, in IDLE with start=1, register in1/in2, unpack sign/exponent/{1,frac}, and go to MUL.
REQ-010 SHALL ignore start outside IDLE; operands SHALL NOT change mid-operation.
REQ-011 SHALL form the 48-bit mantissa product by shift-add, one multiplier bit per cycle, 24 cycles in MUL (5-bit counter, 23 down to 0).
REQ-012 SHALL compute exponent as E1+E2-127 in 10-bit signed arithmetic; sign = s1^s2.
REQ-013 SHALL, in NORM, shift right by one and add 1 to exponent if product bit 47 = 1; else take bits 46:23.
REQ-014 SHALL round (see Configuration); rounding carry-out SHALL renormalize (exponent+1).
REQ-015 SHALL, when final exponent >= 255: final = {sign,8'hFF,23'h0}, ovf=1.
REQ-016 SHALL, when final exponent <= 0: final = {sign,31'h0}, unf=1; no denormal output.
REQ-017 SHALL treat inputs with exponent 0 as signed zero (denormals flushed); zero x finite -> {sign,31'h0}, no flags.
REQ-018 SHALL output 32'h7FC00000 for any NaN input or for zero x infinity.
REQ-019 SHALL output {sign,8'hFF,23'h0} for infinity x nonzero finite or infinity, no flags.
REQ-020 Special cases (REQ-017..019) SHALL still take full latency; there is no early exit.
REQ-021 SHALL register final/ovf/unf at NORM->DONE and assert done for exactly the DONE cycle.
REQ-022 SHALL give fixed latency: start sampled at edge 0; done high after edge 26 for one cycle; ready high again after edge 27.

Reset
REQ-023 SHALL, on rst_n=0, asynchronously set the state to IDLE, final=0, done=0, ovf=0, unf=0, ready=1, and clear the counter.
REQ-024 SHALL abandon any operation in progress on reset mid-operation, with no done pulse afterwards.

Configuration
REQ-025 SHALL, with FP_MUL_RNE_EN defined, round to nearest even using guard, round and sticky bits from the discarded product bits.
REQ-026 SHALL, without FP_MUL_RNE_EN, truncate (round toward zero); latency is identical in both builds.

Structure
REQ-027 SHALL place the FP32 field widths, BIAS=127, the quiet-NaN constant 32'h7FC00000 and the FSM state enum in the shared package fp_pkg.
REQ-028 SHALL use one sub-module, fp_unpack (sign/exponent/mantissa and zero/inf/NaN class), instantiated once per operand.

Verification
REQ-029 Scenario: 3FC00000 x 40000000 -> final=40400000, done exactly 26 cycles after start, ovf=unf=0.
REQ-030 Scenario: C0400000 x 3F000000 -> final=BFC00000.
REQ-031 Scenario: 7F000000 x 7F000000 -> 7F800000, ovf=1; 00800000 x 00800000 -> 00000000, unf=1.
REQ-032 Scenario: 00000000 x 7F800000 -> 7FC00000; 7F800000 x C0000000 -> FF800000.
REQ-033 Scenario: 3FC00001 x 3FC00001 -> 40100002 with FP_MUL_RNE_EN, 40100001 without.
REQ-034 Scenario: rst_n pulsed low at cycle 10 of MUL -> no done pulse, ready=1 immediately; start pulsed while busy -> ignored, first result unchanged.
